// File: rtl/audio_sample_recorder.sv
// Records ADC FIFO samples into an internal RAM and replays them to the DAC FIFO on command.
// read/write are combinational pops/pushes; playback costs 2 cycles per sample (1-cycle RAM fetch).
module audio_sample_recorder #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_rec,
    input  logic             start_play,
    input  logic             stop,
    input  logic             read_ready,
    input  logic [WIDTH-1:0] readdata,
    output logic             read,
    input  logic             write_ready,
    output logic [WIDTH-1:0] writedata,
    output logic             write,
    output logic [AW:0]      rec_len,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_PLAY_FETCH,
        S_PLAY_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [AW:0]     rec_len_q, rec_len_d;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic last_wr;
    logic last_rd;

    // Pops and pushes are combinational so a sample moves in the cycle it is offered.
    assign read  = !reset && (state_q == S_REC) && read_ready && !stop;
    assign write = !reset && (state_q == S_PLAY_WAIT) && write_ready && !stop;

    assign last_wr   = (wr_addr_q == AW'(DEPTH - 1));
    assign last_rd   = ({1'b0, rd_addr_q} == (rec_len_q - (AW+1)'(1)));
    assign writedata = rd_data_q;
    assign rec_len   = rec_len_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        rec_len_d = rec_len_q;
        case (state_q)
            S_IDLE: begin
                if (start_rec) begin
                    state_d   = S_REC;
                    wr_addr_d = '0;
                    rec_len_d = '0;
                end else if (start_play && (rec_len_q != '0)) begin
                    state_d   = S_PLAY_FETCH;
                    rd_addr_d = '0;
                end
            end
            S_REC: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (read) begin
                    wr_addr_d = wr_addr_q + AW'(1);
                    rec_len_d = rec_len_q + (AW+1)'(1);
                    // Full RAM ends the take; nothing is ever overwritten.
                    if (last_wr) state_d = S_IDLE;
                end
            end
            S_PLAY_FETCH: begin
                state_d = stop ? S_IDLE : S_PLAY_WAIT;
            end
            S_PLAY_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (write) begin
                    if (last_rd) begin
                        state_d = S_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                        state_d   = S_PLAY_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            rec_len_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            rec_len_q <= rec_len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (read) mem[wr_addr_q] <= readdata;
    end

    // Read register only loads in FETCH, so writedata holds between pushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (state_q == S_PLAY_FETCH) begin
            rd_data_q <= mem[rd_addr_q];
        end
    end

endmodule

// File: tb/tb_audio_sample_recorder.sv
// Randomized self-checking bench for audio_sample_recorder; expected data comes from a sample queue model.
module tb_audio_sample_recorder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start_rec, start_play, stop, read_ready, write_ready;
    logic [23:0] readdata;
    logic        read, write, busy;
    logic [23:0] writedata;
    logic [12:0] rec_len;

    logic        s_reset, s_start_rec, s_start_play, s_stop, s_read_ready, s_write_ready;
    logic [23:0] s_readdata;
    logic        s_read, s_write, s_busy;
    logic [23:0] s_writedata;
    logic [3:0]  s_rec_len;

    audio_sample_recorder dut (
        .clk(clk), .reset(reset), .start_rec(start_rec), .start_play(start_play), .stop(stop),
        .read_ready(read_ready), .readdata(readdata), .read(read),
        .write_ready(write_ready), .writedata(writedata), .write(write),
        .rec_len(rec_len), .busy(busy)
    );

    audio_sample_recorder #(.WIDTH(24), .DEPTH(8), .AW(3)) dut8 (
        .clk(clk), .reset(s_reset), .start_rec(s_start_rec), .start_play(s_start_play), .stop(s_stop),
        .read_ready(s_read_ready), .readdata(s_readdata), .read(s_read),
        .write_ready(s_write_ready), .writedata(s_writedata), .write(s_write),
        .rec_len(s_rec_len), .busy(s_busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] exp_q[$];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        reset = 0; start_rec = 0; start_play = 0; stop = 0;
        read_ready = 0; write_ready = 0; readdata = '0;
    endtask

    task automatic test_reset;
        tick; idle_inputs; reset = 1; read_ready = 1; #1;
        n_checks++; if (read !== 1'b0) begin n_fail++; $display("FAIL reset_read_forced: got %b expected 0", read); end
        tick; tick; reset = 0; read_ready = 0; #1;
        n_checks++; if (busy !== 1'b0 || rec_len !== 13'd0 || write !== 1'b0 || writedata !== 24'd0) begin
            n_fail++; $display("FAIL reset_state: busy=%b rec_len=%0d write=%b writedata=%0h expected 0/0/0/0", busy, rec_len, write, writedata);
        end
        start_rec = 1;
        for (int k = 0; k < 5; k++) begin
            tick; start_rec = 0; read_ready = 1; readdata = 24'($urandom);
        end
        tick; reset = 1; read_ready = 1; #1;
        n_checks++; if (rec_len !== 13'd5 || read !== 1'b0) begin
            n_fail++; $display("FAIL reset_midrec_pre: rec_len=%0d read=%b expected 5/0", rec_len, read);
        end
        tick; reset = 0; #1;
        n_checks++; if (busy !== 1'b0 || rec_len !== 13'd0 || read !== 1'b0) begin
            n_fail++; $display("FAIL reset_midrec_post: busy=%b rec_len=%0d read=%b expected 0/0/0", busy, rec_len, read);
        end
        read_ready = 0;
    endtask

    task automatic test_record;
        exp_q.delete();
        tick; idle_inputs; start_rec = 1;
        for (int k = 1; k <= 10; k++) begin
            tick; start_rec = 0; read_ready = 1; readdata = 24'(k); #1;
            n_checks++; if (read !== 1'b1) begin n_fail++; $display("FAIL rec_read_%0d: got %b expected 1", k, read); end
            exp_q.push_back(24'(k));
        end
        tick; stop = 1; readdata = 24'd99; #1;
        n_checks++; if (read !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rec_stop_cycle: read=%b busy=%b expected 0/1", read, busy);
        end
        tick; stop = 0; read_ready = 0; #1;
        n_checks++; if (busy !== 1'b0 || rec_len !== 13'd10) begin
            n_fail++; $display("FAIL rec_after_stop: busy=%b rec_len=%0d expected 0/10", busy, rec_len);
        end
    endtask

    // mode 0: write_ready always high, 1: 1-on/3-off, 2: random
    task automatic run_play(input int mode, input int budget);
        int idx = 0;
        int last_w = -100;
        int cyc = 0;
        tick; start_play = 1; #1;
        tick; start_play = 0;
        while (idx < exp_q.size() && cyc < budget) begin
            case (mode)
                0:       write_ready = 1;
                1:       write_ready = (cyc % 4 == 0);
                default: write_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (write) begin
                n_checks++; if (writedata !== exp_q[idx]) begin
                    n_fail++; $display("FAIL play_data_m%0d_%0d: got %0h expected %0h", mode, idx, writedata, exp_q[idx]);
                end
                n_checks++; if ((cyc - last_w < 2) || (mode == 0 && idx > 0 && cyc - last_w != 2)) begin
                    n_fail++; $display("FAIL play_spacing_m%0d_%0d: got %0d cycles expected %s", mode, idx, cyc - last_w, mode == 0 ? "2" : ">=2");
                end
                last_w = cyc;
                idx++;
            end else if (idx > 0 && write_ready == 1'b0) begin
                n_checks++; if (writedata !== exp_q[idx-1] && writedata !== exp_q[idx]) begin
                    n_fail++; $display("FAIL play_hold_m%0d_%0d: got %0h expected %0h or %0h", mode, idx, writedata, exp_q[idx-1], exp_q[idx]);
                end
            end
            tick; cyc++;
        end
        n_checks++; if (idx != exp_q.size()) begin
            n_fail++; $display("FAIL play_count_m%0d: got %0d writes expected %0d", mode, idx, exp_q.size());
        end
        write_ready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (write !== 1'b0 || busy !== 1'b0 || rec_len !== 13'(exp_q.size())) begin
                n_fail++; $display("FAIL play_end_m%0d: write=%b busy=%b rec_len=%0d expected 0/0/%0d", mode, write, busy, rec_len, exp_q.size());
            end
            tick;
        end
        write_ready = 0;
    endtask

    task automatic test_random;
        for (int it = 0; it < 3; it++) begin
            int n = $urandom_range(1, 20);
            int cyc = 0;
            exp_q.delete();
            tick; idle_inputs; start_rec = 1;
            tick; start_rec = 0;
            while (exp_q.size() < n && cyc < 400) begin
                read_ready = 1'($urandom_range(0, 1));
                readdata = 24'($urandom);
                #1;
                n_checks++; if (read !== read_ready) begin
                    n_fail++; $display("FAIL rand_read_%0d: got %b expected %b", it, read, read_ready);
                end
                if (read_ready) exp_q.push_back(readdata);
                tick; cyc++;
            end
            read_ready = 1; stop = 1;
            tick; stop = 0; read_ready = 0; #1;
            n_checks++; if (rec_len !== 13'(n) || busy !== 1'b0) begin
                n_fail++; $display("FAIL rand_reclen_%0d: rec_len=%0d busy=%b expected %0d/0", it, rec_len, busy, n);
            end
            run_play(2, 600);
        end
    endtask

    task automatic test_corner;
        tick; idle_inputs; reset = 1;
        tick; reset = 0; start_play = 1; write_ready = 1;
        for (int k = 0; k < 5; k++) begin
            tick; start_play = 0; #1;
            n_checks++; if (busy !== 1'b0 || write !== 1'b0) begin
                n_fail++; $display("FAIL play_empty_%0d: busy=%b write=%b expected 0/0", k, busy, write);
            end
        end
        write_ready = 0; start_rec = 1; start_play = 1;
        tick; start_rec = 0; start_play = 0; read_ready = 1; readdata = 24'h7; #1;
        n_checks++; if (busy !== 1'b1 || read !== 1'b1) begin
            n_fail++; $display("FAIL rec_priority: busy=%b read=%b expected 1/1", busy, read);
        end
        tick; read_ready = 0; stop = 1;
        tick; stop = 1; #1;
        n_checks++; if (busy !== 1'b0 || rec_len !== 13'd1) begin
            n_fail++; $display("FAIL stop_idle: busy=%b rec_len=%0d expected 0/1", busy, rec_len);
        end
        tick; stop = 0;
    endtask

    task automatic test_depth8;
        logic [23:0] q8[$];
        int nreads = 0;
        int idx = 0;
        tick; s_reset = 1;
        tick; s_reset = 0; s_start_rec = 1;
        for (int k = 0; k < 15; k++) begin
            tick; s_start_rec = 0; s_read_ready = 1; s_readdata = 24'($urandom); #1;
            if (s_read) begin nreads++; q8.push_back(s_readdata); end
        end
        n_checks++; if (nreads != 8 || s_busy !== 1'b0 || s_rec_len !== 4'd8 || s_read !== 1'b0) begin
            n_fail++; $display("FAIL depth8_full: reads=%0d busy=%b rec_len=%0d read=%b expected 8/0/8/0", nreads, s_busy, s_rec_len, s_read);
        end
        tick; s_read_ready = 0; s_start_play = 1; s_write_ready = 1;
        for (int k = 0; k < 30 && idx < 8; k++) begin
            tick; s_start_play = 0; #1;
            if (s_write) begin
                n_checks++; if (s_writedata !== q8[idx]) begin
                    n_fail++; $display("FAIL depth8_play_%0d: got %0h expected %0h", idx, s_writedata, q8[idx]);
                end
                idx++;
            end
        end
        n_checks++; if (idx != 8) begin n_fail++; $display("FAIL depth8_count: got %0d expected 8", idx); end
        s_write_ready = 0;
    endtask

    initial begin
        idle_inputs;
        s_reset = 1; s_start_rec = 0; s_start_play = 0; s_stop = 0;
        s_read_ready = 0; s_write_ready = 0; s_readdata = '0;
        test_reset;
        test_record;
        run_play(0, 60);
        run_play(1, 100);
        test_random;
        test_corner;
        test_depth8;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
